// File: rtl/sprite_capture.sv
// Sprite stream capture: rebuilds the 16x8 half-width bitmap from a 1-bit sprite pixel stream.
// Optional mirror-consistency flag enabled by defining SPRITE_CAPTURE_MIRROR_CHECK_EN.
module sprite_capture #(
  parameter int ROWS   = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vstart,
  input  logic              load,
  input  logic              hstart,
  input  logic              gfx,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_bits,
  output logic              in_progress,
  output logic              done,
  output logic [7:0]        frame_count,
  output logic              mirror_err,
  output logic [2:0]        state_dbg
);

  // Strobes are plain levels sampled on clk: each one only acts in the single
  // state that waits for it (vstart in IDLE, load in WAIT_LOAD, hstart in
  // WAIT_HSTART) and is ignored everywhere else; there is no back-pressure.
  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    WAIT_LOAD   = 3'd1,
    WAIT_HSTART = 3'd2,
    SAMPLE      = 3'd3,
    WRITE       = 3'd4
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] ycount;
  logic [3:0]        xcount;
  logic [7:0]        left;
  logic [7:0]        ram [ROWS];
`ifdef SPRITE_CAPTURE_MIRROR_CHECK_EN
  logic [7:0]        right;
`endif

  assign in_progress = (state != IDLE);
  assign state_dbg   = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ycount      <= '0;
      xcount      <= '0;
      left        <= '0;
      rd_bits     <= '0;
      done        <= 1'b0;
      frame_count <= '0;
      for (int i = 0; i < ROWS; i++) ram[i] <= '0;
`ifdef SPRITE_CAPTURE_MIRROR_CHECK_EN
      right      <= '0;
      mirror_err <= 1'b0;
`endif
    end else begin
      done    <= 1'b0;
      rd_bits <= ram[rd_addr];
      case (state)
        IDLE: begin
          ycount <= '0;
          if (vstart) state <= WAIT_LOAD;
        end
        WAIT_LOAD: begin
          xcount <= '0;
          if (load) state <= WAIT_HSTART;
        end
        WAIT_HSTART: begin
          if (hstart) state <= SAMPLE;
        end
        SAMPLE: begin
          // Right half arrives mirrored: column 8 holds bit 7, column 15 holds bit 0.
          if (!xcount[3]) left[xcount[2:0]] <= gfx;
`ifdef SPRITE_CAPTURE_MIRROR_CHECK_EN
          else            right[~xcount[2:0]] <= gfx;
`endif
          xcount <= xcount + 4'd1;
          if (xcount == 4'd15) state <= WRITE;
        end
        WRITE: begin
          ram[ycount] <= left;
          ycount      <= ycount + ADDR_W'(1);
`ifdef SPRITE_CAPTURE_MIRROR_CHECK_EN
          if (right != left) mirror_err <= 1'b1;
`endif
          if (ycount == ADDR_W'(ROWS - 1)) begin
            done        <= 1'b1;
            frame_count <= frame_count + 8'd1;
            state       <= IDLE;
          end else begin
            state <= WAIT_LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SPRITE_CAPTURE_MIRROR_CHECK_EN
  assign mirror_err = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_capture.sv
// Directed bench for sprite_capture: frames are driven line by line and the bitmap is read back.
module tb_sprite_capture;
  localparam int ROWS   = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              reset, vstart, load, hstart, gfx;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_bits;
  logic              in_progress, done, mirror_err;
  logic [7:0]        frame_count;
  logic [2:0]        state_dbg;

  sprite_capture #(.ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .vstart(vstart), .load(load), .hstart(hstart),
    .gfx(gfx), .rd_addr(rd_addr), .rd_bits(rd_bits), .in_progress(in_progress),
    .done(done), .frame_count(frame_count), .mirror_err(mirror_err),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  int   done_pulses = 0;
  int   done_wide = 0;
  logic done_prev = 1'b0;
  logic [7:0]  exp_q[$];
  logic [15:0] frame_pix [ROWS];
  logic        exp_me;

  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_pulses++;
      if (done_prev === 1'b1) done_wide++;
    end
    done_prev = done;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] mirror_pix(input logic [7:0] b);
    logic [15:0] p;
    for (int k = 0; k < 8; k++) begin
      p[k]      = b[k];
      p[15 - k] = b[k];
    end
    return p;
  endfunction

  task automatic send_pixels(input logic [15:0] pix);
    hstart = 1'b1; tick(); hstart = 1'b0;
    for (int k = 0; k < 16; k++) begin
      gfx = pix[k]; tick();
    end
    gfx = 1'b0;
    tick();  // WRITE
  endtask

  task automatic do_line(input logic [15:0] pix);
    load = 1'b1; tick(); load = 1'b0;
    send_pixels(pix);
  endtask

  task automatic do_frame();
    vstart = 1'b1; tick(); vstart = 1'b0;
    for (int y = 0; y < ROWS; y++) do_line(frame_pix[y]);
    check("done_after_frame", done, 1);
  endtask

  task automatic read_rows(input string tag);
    for (int r = 0; r < ROWS; r++) begin
      rd_addr = ADDR_W'(r);
      tick();
      check(tag, rd_bits, exp_q.pop_front());
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); reset = 1'b0;
  endtask

  logic [7:0] car_rom [ROWS] = '{8'h18, 8'h3C, 8'h7E, 8'h7E, 8'hFF, 8'hDB, 8'hFF, 8'h7E,
                                 8'h3C, 8'h3C, 8'h7E, 8'hFF, 8'hFF, 8'h7E, 8'h24, 8'h66};

  initial begin
    int base;
`ifdef SPRITE_CAPTURE_MIRROR_CHECK_EN
    exp_me = 1'b1;
`else
    exp_me = 1'b0;
`endif
    vstart = 0; load = 0; hstart = 0; gfx = 0; rd_addr = '0; reset = 0;
    do_reset();
    check("rst_in_progress", in_progress, 0);
    check("rst_done", done, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_mirror_err", mirror_err, 0);
    check("rst_rd_bits", rd_bits, 0);

    // 1: car bitmap as the renderer would emit it
    for (int y = 0; y < ROWS; y++) begin
      frame_pix[y] = mirror_pix(car_rom[y]);
      exp_q.push_back(car_rom[y]);
    end
    base = done_pulses;
    do_frame();
    tick();
    check("car_done_pulses", done_pulses - base, 1);
    check("car_frame_count", frame_count, 1);
    check("car_idle", in_progress, 0);
    read_rows("car_row");

    // 2: pixels only at first and last column
    for (int y = 0; y < ROWS; y++) begin
      frame_pix[y] = 16'h8001;
      exp_q.push_back(8'h01);
    end
    do_frame();
    check("edge_frame_count", frame_count, 2);
    check("edge_mirror_err", mirror_err, 0);
    read_rows("edge_row");

    // 3: row 3 asymmetric
    vstart = 1'b1; tick(); vstart = 1'b0;
    for (int y = 0; y < ROWS; y++) begin
      if (y == 3) begin
        do_line(16'h0002);
        exp_q.push_back(8'h02);
        check("mirr_err_after_row3", mirror_err, 32'(exp_me));
      end else begin
        do_line(mirror_pix(8'h81));
        exp_q.push_back(8'h81);
        if (y == 2) check("mirr_err_before_row3", mirror_err, 0);
      end
    end
    check("mirr_done", done, 1);
    check("mirr_err_sticky", mirror_err, 32'(exp_me));
    read_rows("mirr_row");

    // 4: reset mid-capture at row 7, xcount 5
    vstart = 1'b1; tick(); vstart = 1'b0;
    for (int y = 0; y < 7; y++) do_line(16'hFFFF);
    load = 1'b1; tick(); load = 1'b0;
    hstart = 1'b1; tick(); hstart = 1'b0;
    for (int k = 0; k < 5; k++) begin
      gfx = 1'b1; tick();
    end
    check("abort_sampling", state_dbg, 3);
    reset = 1'b1; tick(); reset = 1'b0; gfx = 1'b0;
    check("abort_in_progress", in_progress, 0);
    check("abort_frame_count", frame_count, 0);
    check("abort_mirror_err", mirror_err, 0);
    check("abort_rd_bits", rd_bits, 0);
    for (int y = 0; y < ROWS; y++) exp_q.push_back(8'h00);
    read_rows("abort_row");
    for (int y = 0; y < ROWS; y++) begin
      frame_pix[y] = mirror_pix(8'(y * 17 + 3));
      exp_q.push_back(8'(y * 17 + 3));
    end
    do_frame();
    check("fresh_frame_count", frame_count, 1);
    read_rows("fresh_row");

    // 5: strobe qualification
    vstart = 1'b1; tick();
    check("q_wait_load", state_dbg, 1);
    hstart = 1'b1; tick(); hstart = 1'b0;
    check("q_hstart_ignored", state_dbg, 1);
    load = 1'b1; hstart = 1'b1; tick(); load = 1'b0; hstart = 1'b0;
    check("q_load_hstart", state_dbg, 2);
    tick();
    check("q_still_wait_h", state_dbg, 2);
    send_pixels(mirror_pix(8'hC3));
    exp_q.push_back(8'hC3);
    for (int y = 1; y < ROWS; y++) begin
      if (y == 3) vstart = 1'b0;
      do_line(mirror_pix(8'(y)));
      exp_q.push_back(8'(y));
    end
    check("q_done", done, 1);
    tick();
    check("q_frame_count", frame_count, 2);
    check("q_idle", in_progress, 0);
    read_rows("q_row");

    // 6: 256 back-to-back frames
    do_reset();
    for (int y = 0; y < ROWS; y++) frame_pix[y] = 16'h8001;
    base = done_pulses;
    for (int f = 0; f < 256; f++) begin
      do_frame();
      if (f == 254) check("wrap_fc_255", frame_count, 255);
    end
    check("wrap_frame_count", frame_count, 0);
    tick();
    check("wrap_done_pulses", done_pulses - base, 256);
    check("done_width", done_wide, 0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/sprite_capture.md
Name: sprite_capture

Overview:
- Inverse of the sprite renderer: watches a 1-bit sprite pixel stream, timed by the same vstart/load/hstart strobes, and rebuilds the 16x8 half-width bitmap the renderer was fed.
- Captured rows go into an internal 16x8 bitmap RAM with a registered read port, in the same address/bits format as the car bitmap ROM.
- Used as a self-check/readback block beside the renderer in test tops.

Parameters:
ROWS, 16, sprite height in scanlines; power of 2, 2..16.
ADDR_W, 4, row address width; must equal log2(ROWS).

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
vstart  input  1  start of sprite frame (top border), level or pulse
load  input  1  per-line arm strobe (driven from hsync)
hstart  input  1  start of sprite scanline (left border)
gfx  input  1  sprite pixel stream under capture
rd_addr  input  ADDR_W  bitmap row to read
rd_bits  output  8  registered row data, bit i = pixel column i
in_progress  output  1  1 while not in IDLE
done  output  1  one-cycle pulse when the last row is written
frame_count  output  8  completed frames, wraps 255->0
mirror_err  output  1  sticky mirror mismatch flag (see Optional Feature)

Behaviour:
- Reset (clk edge with reset=1):
  - state=IDLE; ycount=0; xcount=0; shift regs=0.
  - All ROWS RAM rows=0; rd_bits=0; done=0; frame_count=0; mirror_err=0.
  - Reset mid-capture aborts; the partial row is discarded.
- States:
  - IDLE: ycount<=0. vstart=1 -> WAIT_LOAD.
  - WAIT_LOAD: xcount<=0. load=1 -> WAIT_HSTART.
  - WAIT_HSTART: hstart=1 at cycle T -> SAMPLE.
  - SAMPLE: runs cycles T+1..T+16, sampling gfx once per cycle.
    - xcount 0..7: left[xcount] <= gfx.
    - xcount 8..15: right[15-xcount] <= gfx (mirrored index, matches the renderer's mirroring).
    - xcount increments each cycle; at xcount==15 (pre-increment) -> WRITE.
  - WRITE (cycle T+17): ram[ycount] <= left; ycount <= ycount+1.
    - If ycount==ROWS-1 (pre-increment): done<=1, frame_count<=frame_count+1, -> IDLE.
    - Otherwise -> WAIT_LOAD.
  - Unused encodings -> IDLE.
- Strobe qualification:
  - vstart is ignored outside IDLE.
  - load and hstart are ignored outside their wait states; hstart in WAIT_LOAD is ignored.
  - load and hstart together in WAIT_LOAD: advance to WAIT_HSTART only; the hstart is not consumed.
  - vstart held several lines does not restart a capture.
- in_progress = (state != IDLE), combinational from state.
- done is high exactly one cycle, the cycle after WRITE of the last row.
- Read port:
  - rd_bits <= ram[rd_addr] every cycle; 1-cycle latency.
  - Read of the row being written in the same cycle returns the old data.
  - rd_addr is never out of range (ADDR_W exact).
- ycount is ADDR_W bits and wraps to 0 after the last row.
- Back-to-back frames: vstart in the cycle right after the last WRITE is accepted, since the state is already IDLE.

Optional Feature:
- Macro: SPRITE_CAPTURE_MIRROR_CHECK_EN.
- Defined:
  - In WRITE, if right != left, mirror_err <= 1.
  - mirror_err is sticky until reset.
  - Row is written from left regardless of the mismatch.
- Undefined:
  - right half is sampled but not compared.
  - mirror_err is tied to 0.
  - right register may be optimised away.

Test Plan:
1. Renderer + car bitmap ROM drive gfx/vstart/load/hstart, player_x=40, player_y=50 -> after one frame done pulses once; rd_addr 0..15 returns ROM bytes exactly (1-cycle latency); frame_count=1.
2. hstart at T, gfx=1 only at T+1 and T+16, each line, 16 lines -> every row reads 8'h01; mirror_err=0.
3. Mirror check enabled; row 3 gfx=1 only at T+2 -> row 3 reads 8'h02, mirror_err=1 after row 3 WRITE and stays 1; disabled -> mirror_err=0.
4. Reset asserted at SAMPLE xcount=5 of row 7 -> next cycle in_progress=0, all rows 0, frame_count=0; a fresh frame then captures normally.
5. vstart held 3 lines, hstart pulsed in WAIT_LOAD, then load -> hstart in WAIT_LOAD ignored; capture starts only at the hstart after load; 1 frame counted.
6. 256 consecutive frames -> frame_count wraps to 0; done pulses 256 times, each exactly 1 cycle wide.
